// File: rtl/control_rw_flow_burst.sv
// control_rw_flow_burst
//   Sequences memory read/write bursts. A write beat is SAMPLE (capture the
//   input data) followed by WMEM (memory write strobe). A read beat is RMEM
//   (memory read strobe) followed by TX, where TxData is held until the
//   transmitter returns txDone or the TX timeout expires.
//
// Ports
//   clk        : single clock, rising-edge active
//   reset      : asynchronous active-low reset
//   validCmd   : command request, accepted only in IDLE with active=1, mode=1
//   active     : block enable; 0 in any busy state aborts to IDLE
//   mode       : 1 = memory-access mode, 0 = ALU mode (commands ignored)
//   RW         : 1 = read burst, 0 = write burst (sampled at accept)
//   burstLen   : beats minus one (sampled at accept)
//   txDone     : transmitter finished the current beat (used only in TX)
//   AccessMem  : memory strobe (WMEM, RMEM)
//   RWMem      : memory direction, 1 = read (RMEM)
//   SampleData : input-sample strobe (SAMPLE)
//   TxData     : transmit request (TX)
//   Busy       : high in every state except IDLE
//   Error      : sticky TX-timeout flag, cleared on the next accept
//   beatCnt    : index of the current beat, held in IDLE

module control_rw_flow_burst #(
    parameter int unsigned BURST_W    = 4,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               validCmd,
    input  logic               active,
    input  logic               mode,
    input  logic               RW,
    input  logic [BURST_W-1:0] burstLen,
    input  logic               txDone,
    output logic               AccessMem,
    output logic               RWMem,
    output logic               SampleData,
    output logic               TxData,
    output logic               Busy,
    output logic               Error,
    output logic [BURST_W-1:0] beatCnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_WMEM   = 3'd2;
    localparam logic [2:0] S_RMEM   = 3'd3;
    localparam logic [2:0] S_TX     = 3'd4;

    // Value of the TX-cycle counter during the last cycle TxData may be held.
    localparam logic [7:0] TX_LAST = 8'(TX_TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [BURST_W-1:0] r_len;
    logic [BURST_W-1:0] r_beat;
    logic               r_err;
    logic [7:0]         r_txcnt;

    logic [2:0]         w_state_d;
    logic [BURST_W-1:0] w_len_d;
    logic [BURST_W-1:0] w_beat_d;
    logic               w_err_d;
    logic [7:0]         w_txcnt_d;
    logic               w_last;

    always_comb begin
        w_state_d = r_state;
        w_len_d   = r_len;
        w_beat_d  = r_beat;
        w_err_d   = r_err;
        w_txcnt_d = r_txcnt;
        w_last    = (r_beat == r_len);

        // Dropping the enable aborts any burst; beat index and Error are kept.
        if (r_state != S_IDLE && !active) begin
            w_state_d = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (validCmd && active && mode) begin
                        w_len_d   = burstLen;
                        w_beat_d  = '0;
                        w_err_d   = 1'b0;
                        // Direction only selects the entry state; the state
                        // path then carries it for the rest of the burst.
                        w_state_d = RW ? S_RMEM : S_SAMPLE;
                    end
                end
                S_SAMPLE: w_state_d = S_WMEM;
                S_WMEM: begin
                    if (w_last) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_beat_d  = r_beat + 1'b1;
                        w_state_d = S_SAMPLE;
                    end
                end
                S_RMEM: begin
                    w_state_d = S_TX;
                    w_txcnt_d = '0;
                end
                S_TX: begin
                    // txDone wins over the timeout on the final allowed cycle.
                    if (txDone) begin
                        if (w_last) begin
                            w_state_d = S_IDLE;
                        end else begin
                            w_beat_d  = r_beat + 1'b1;
                            w_state_d = S_RMEM;
                        end
                    end else if (r_txcnt == TX_LAST) begin
                        w_err_d   = 1'b1;
                        w_state_d = S_IDLE;
                    end else begin
                        w_txcnt_d = r_txcnt + 8'd1;
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_txcnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_len   <= w_len_d;
            r_beat  <= w_beat_d;
            r_err   <= w_err_d;
            r_txcnt <= w_txcnt_d;
        end
    end

    // Moore outputs: decoded from the state register only.
    always_comb begin
        AccessMem  = 1'b0;
        RWMem      = 1'b0;
        SampleData = 1'b0;
        TxData     = 1'b0;
        Busy       = (r_state != S_IDLE);
        case (r_state)
            S_SAMPLE: SampleData = 1'b1;
            S_WMEM:   AccessMem  = 1'b1;
            S_RMEM: begin
                AccessMem = 1'b1;
                RWMem     = 1'b1;
            end
            S_TX:     TxData     = 1'b1;
            default: ;
        endcase
    end

    assign Error   = r_err;
    assign beatCnt = r_beat;

endmodule

// File: doc/control_rw_flow_burst.md
CONTROL_RW_FLOW_BURST -- requirements
Module: control_rw_flow_burst

Interface
REQ-001 SHALL provide parameter BURST_W, default 4, width of burst-length field; beats per burst = burstLen+1.
REQ-002 SHALL provide parameter TX_TIMEOUT, default 16, max cycles TxData is held awaiting txDone (legal range 2..255).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port validCmd  in  1  command request.
REQ-006 SHALL have port active  in  1  block enable.
REQ-007 SHALL have port mode  in  1  1 = memory-access mode, 0 = ALU mode (commands ignored).
REQ-008 SHALL have port RW  in  1  1 = read burst, 0 = write burst.
REQ-009 SHALL have port burstLen  in  BURST_W  beats minus one.
REQ-010 SHALL have port txDone  in  1  transmitter finished current beat.
REQ-011 SHALL have ports AccessMem, RWMem, SampleData, TxData, Busy  out  1 each  memory strobe, memory direction (1 = read), input-sample strobe, transmit request, block busy.
REQ-012 SHALL have port Error  out  1  sticky transmit-timeout flag.
REQ-013 SHALL have port beatCnt  out  BURST_W  index of current beat.

Function
REQ-014 States SHALL be IDLE, SAMPLE, WMEM, RMEM, TX; outputs SHALL be decoded from the state register only (Moore), except Error and beatCnt, which are registers.
REQ-015 Accept condition: state IDLE and validCmd=1 and active=1 and mode=1, sampled at a rising edge; RW and burstLen SHALL be latched then and later changes ignored until IDLE.
REQ-016 On accept, beatCnt SHALL load 0 and Error SHALL clear; next state SAMPLE if RW=0, RMEM if RW=1.
REQ-017 SAMPLE: SampleData=1 for exactly one cycle, then WMEM.
REQ-018 WMEM: AccessMem=1, RWMem=0 for one cycle; if beatCnt==latched burstLen go IDLE, else beatCnt+1 and go SAMPLE.
REQ-019 RMEM: AccessMem=1, RWMem=1 for one cycle, then TX.
REQ-020 TX: TxData=1 held; txDone=1 at a rising edge ends the beat: if last beat go IDLE, else beatCnt+1 and go RMEM.
REQ-021 A TX-cycle counter SHALL clear on TX entry; if TX_TIMEOUT TX cycles elapse without txDone, set Error=1, go IDLE and abandon the remaining beats; txDone on the final allowed cycle completes normally.
REQ-022 txDone outside TX SHALL be ignored; validCmd while Busy SHALL be ignored (no queueing).
REQ-023 active=0 sampled in any non-IDLE state SHALL force IDLE at that edge; Error unchanged.
REQ-024 Busy SHALL be 1 in every state except IDLE; all strobes 0 in IDLE.
REQ-025 Latency: accept at edge k makes the first strobe visible in the cycle after edge k; burst of N write beats occupies 2N cycles.
REQ-026 beatCnt SHALL hold its last value in IDLE until the next accept; with burstLen at maximum it SHALL reach 2^BURST_W-1 without wrap.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, all outputs 0, beatCnt 0, Error 0, timeout counter 0, regardless of clk.
REQ-028 Release of reset SHALL take effect at the next rising edge; accept is possible on that edge.

Verification (BURST_W=4, TX_TIMEOUT=4)
REQ-029 Single write, burstLen=0 -> SampleData 1 cycle, then AccessMem=1/RWMem=0 1 cycle, Busy high exactly 2 cycles, beatCnt 0.
REQ-030 Read, burstLen=2, txDone on 2nd TX cycle each beat -> 3 RMEM pulses, beatCnt 0,1,2, Busy high 9 cycles, Error 0.
REQ-031 Read, txDone never -> TxData high 4 cycles, then Error=1, Busy=0; next accepted command clears Error.
REQ-032 validCmd=1 with mode=0 or active=0 -> no strobes, Busy stays 0.
REQ-033 Write burstLen=15 with active dropped during beat 3 -> IDLE at that edge, beatCnt holds 3, Error 0.
REQ-034 reset=0 asserted mid-TX between clock edges -> all outputs 0 immediately; after release a new write is accepted normally.
